com_fifo_rd_prefetch: RTL and testbench
=======================================

// Module: com_fifo_rd_prefetch
// PURPOSE
// - Read-side stage directly downstream of the async FIFO controller, in the rd_clk domain.
// - Turns the controller's rd_en/rd_empty/rd_addr interface plus a RAM with fixed read
//   latency into a registered valid/ready stream.
// - Tracks reads in flight, buffers returning RAM data and applies backpressure so that no
//   word is lost or duplicated; sustains one word per cycle.
// PARAMETERS
// - DW       32  data width of RAM words and o_data
// - AW       3   RAM address width (the controller's AW)
// - RAM_LAT  1   RAM read latency in cycles; legal values are 1 and 2 (parameter assert)
// - BUFD     RAM_LAT+1  output buffer depth (derived localparam, not overridable)
// PORTS
// - clk            in   1         clock (FIFO rd_clk)
// - rst_n          in   1         reset; synchronous, active-low
// - clear          in   1         synchronous flush; driven from the controller's sync_rd_clear
// - fifo_rd_empty  in   1         controller rd_empty
// - fifo_rd_addr   in   AW        controller rd_addr
// - fifo_rd_en     out  1         controller rd_en; combinational
// - ram_rd_en      out  1         RAM read strobe; equal to fifo_rd_en
// - ram_rd_addr    out  AW        RAM read address; equal to fifo_rd_addr
// - ram_rdata      in   DW        RAM data, valid RAM_LAT cycles after ram_rd_en is sampled
// - o_valid        out  1         output word valid
// - o_ready        in   1         consumer ready
// - o_data         out  DW        output word
// - o_level        out  $clog2(BUFD+1)  buffer occupancy
// BEHAVIOUR
// - Reset and clear:
//   - rst_n=0 at a clk edge: occupancy=0, in-flight pipe=0, read/write pointers=0.
//   - Resulting outputs: o_valid=0, o_level=0, o_data=0.
//   - fifo_rd_en is forced to 0 in every cycle where rst_n=0 or clear=1.
//   - clear has the same effect as reset. Words already in flight are discarded (their pipe
//     bits are cleared), so no stale word appears after clear.
// - In-flight pipe: a RAM_LAT-bit shift register, bit0 <= ram_rd_en.
//   - pipe[RAM_LAT-1]=1 means ram_rdata is valid this cycle; it is written into the buffer
//     at the clock edge that ends that cycle.
//   - inflight = popcount(pipe).
// - pop = o_valid && o_ready.
// - Issue rule: fifo_rd_en = !fifo_rd_empty && !clear && rst_n
//   && (o_level + inflight < BUFD + pop).
//   - This guarantees the buffer never overflows.
//   - It also gives full throughput: a pop frees a credit in the same cycle.
// - Buffer: a BUFD-entry circular buffer.
//   - Write pointer and read pointer wrap at BUFD (BUFD need not be a power of 2).
//   - o_data = entry at the read pointer. It is held stable while o_valid && !o_ready.
//   - o_valid = (o_level != 0).
// - Occupancy update: o_level_next = o_level + capture - pop.
//   - Simultaneous capture and pop leaves o_level unchanged.
//   - A capture into an empty buffer raises o_valid in the next cycle. There is no
//     same-cycle bypass.
// - Latency: read issued in cycle t -> o_valid=1 with that word in cycle t+RAM_LAT+1.
// - Ordering: words leave strictly in issue order.
// - Assertions:
//   - capture while o_level==BUFD must never happen (overflow).
//   - fifo_rd_en while fifo_rd_empty must never happen.
// TESTING
// - Reset: rst_n=0 for 2 cycles with fifo_rd_empty=0 -> fifo_rd_en=0 and o_valid=0 in
//   both cycles; o_level=0 after release.
// - Single word, RAM_LAT=1: empty falls in cycle 10 with 0xA5 at the RAM address ->
//   fifo_rd_en=1 in cycle 10; o_valid=1 and o_data=0xA5 from cycle 12.
// - Stream, RAM_LAT=1 and RAM_LAT=2: 16 words 0..15, o_ready=1 -> o_valid stays high for
//   16 consecutive cycles with data 0..15 in order; fifo_rd_en has no bubbles.
// - Backpressure: o_ready=0 with the FIFO non-empty -> exactly BUFD reads issued, then
//   fifo_rd_en=0, o_level=BUFD, o_data held.
//   - Then raise o_ready -> remaining words in order; no loss and no duplicate.
// - Clear mid-stream: clear=1 for one cycle while 1 word is in flight and o_level=1 ->
//   o_valid=0 in the next cycle.
//   - The in-flight word is never output.
//   - The first word out afterwards is the first word written after the clear.
// - Pointer wrap: 3*BUFD words with o_ready toggling every cycle -> all words delivered in
//   order across several pointer wraps; o_level never exceeds BUFD.

Source files
------------

// File: rtl/com_fifo_rd_prefetch.sv
// Read-side prefetch stage for the async FIFO: turns rd_en/rd_empty/rd_addr
// plus a fixed-latency RAM into a registered valid/ready stream.
module com_fifo_rd_prefetch #(
  parameter int DW      = 32,
  parameter int AW      = 3,
  parameter int RAM_LAT = 1,
  localparam int BUFD   = RAM_LAT + 1,
  localparam int LW     = $clog2(BUFD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          fifo_rd_empty,
  input  logic [AW-1:0] fifo_rd_addr,
  output logic          fifo_rd_en,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rdata,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [LW-1:0] o_level
);

  localparam int PW = $clog2(BUFD);

  if (RAM_LAT < 1 || RAM_LAT > 2) begin : g_bad_lat
    $error("RAM_LAT must be 1 or 2");
  end

  logic [RAM_LAT-1:0] pipe_q, pipe_d;
  logic [LW-1:0]      level_q, level_d;
  logic [PW-1:0]      wr_q, wr_d;
  logic [PW-1:0]      rd_q, rd_d;
  logic [DW-1:0]      mem_q [BUFD];
  logic [LW:0]        inflight;
  logic               capture;
  logic               pop;
  logic               issue;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUFD - 1)) ? '0 : p + 1'b1;
  endfunction

  assign capture     = pipe_q[RAM_LAT-1];
  assign o_valid     = (level_q != '0);
  assign pop         = o_valid && o_ready;
  assign o_data      = mem_q[rd_q];
  assign o_level     = level_q;
  assign fifo_rd_en  = issue;
  assign ram_rd_en   = issue;
  assign ram_rd_addr = fifo_rd_addr;

  // Count reads in flight; a pop returns its credit in the same cycle.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < RAM_LAT; k++) begin
      inflight = inflight + (LW+1)'(pipe_q[k]);
    end
    issue = !fifo_rd_empty && !clear && rst_n &&
            (({1'b0, level_q} + inflight) <
             ((LW+1)'(BUFD) + (LW+1)'(pop)));
  end

  // Next-state for pipe, pointers and occupancy.
  always_comb begin
    pipe_d  = RAM_LAT'({pipe_q, issue});
    level_d = level_q + LW'(capture) - LW'(pop);
    wr_d    = capture ? ptr_inc(wr_q) : wr_q;
    rd_d    = pop ? ptr_inc(rd_q) : rd_q;
  end

  // State update; clear drops buffered and in-flight words like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      pipe_q  <= '0;
      level_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int k = 0; k < BUFD; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      pipe_q  <= pipe_d;
      level_q <= level_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      if (capture) begin
        mem_q[wr_q] <= ram_rdata;
      end
    end
  end

  // Overflow and read-while-empty must never occur.
  always @(posedge clk) begin
    if (rst_n && !clear) begin
      assert (!(capture && level_q == LW'(BUFD)))
        else $error("prefetch buffer overflow");
      assert (!(fifo_rd_en && fifo_rd_empty))
        else $error("read issued while empty");
    end
  end

endmodule

// File: tb/tb_com_fifo_rd_prefetch.sv
// Bench for com_fifo_rd_prefetch: RAM_LAT=1 and RAM_LAT=2 instances
// share stimulus; each has its own FIFO/RAM model and ordered scoreboard.
module tb_com_fifo_rd_prefetch;

  localparam int DW = 32;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          clear;
  logic          rdy;
  logic          empty  [2];
  logic          en     [2];
  logic          ren    [2];
  logic          ovalid [2];
  logic [AW-1:0] faddr  [2];
  logic [AW-1:0] raddr  [2];
  logic [DW-1:0] rdata  [2];
  logic [DW-1:0] odata  [2];
  logic [1:0]    olvl   [2];
  logic [DW-1:0] src    [2][256];
  logic [DW-1:0] p1     [2];
  logic [DW-1:0] p2     [2];
  int            n_avail[2];
  int            rd_ptr [2];
  int            out_ptr[2];
  int            ramerr [2];
  int            pass_cnt = 0;
  int            chk_cnt  = 0;

  task automatic chk(input string tag, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    com_fifo_rd_prefetch #(
      .DW(DW), .AW(AW), .RAM_LAT(g + 1)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .fifo_rd_empty(empty[g]),
      .fifo_rd_addr (faddr[g]),
      .fifo_rd_en   (en[g]),
      .ram_rd_en    (ren[g]),
      .ram_rd_addr  (raddr[g]),
      .ram_rdata    (rdata[g]),
      .o_valid      (ovalid[g]),
      .o_ready      (rdy),
      .o_data       (odata[g]),
      .o_level      (olvl[g])
    );

    assign empty[g] = (rd_ptr[g] >= n_avail[g]);
    assign faddr[g] = AW'(rd_ptr[g]);
    assign rdata[g] = (g == 0) ? p1[g] : p2[g];

    always @(posedge clk) begin
      if (!rst_n) begin
        rd_ptr[g]  <= 0;
        out_ptr[g] <= 0;
        ramerr[g]  <= 0;
      end else if (clear) begin
        out_ptr[g] <= rd_ptr[g];
      end else begin
        if (en[g]) rd_ptr[g] <= rd_ptr[g] + 1;
        if (ovalid[g] && rdy) begin
          chk($sformatf("order%0d_%0d", g, out_ptr[g]),
              odata[g], src[g][out_ptr[g]]);
          out_ptr[g] <= out_ptr[g] + 1;
        end
        if (ren[g] !== en[g] || raddr[g] !== faddr[g])
          ramerr[g] <= ramerr[g] + 1;
      end
      if (ren[g]) p1[g] <= src[g][rd_ptr[g]];
      p2[g] <= p1[g];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    for (int i = 0; i < 2; i++) begin
      src[i][n_avail[i]] = w;
      n_avail[i]++;
    end
  endtask

  int enb[2];
  int vb[2];
  int ec[2];
  int maxl[2];

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    rdy   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_avail[i] = 0;
      for (int k = 0; k < 256; k++) src[i][k] = '0;
    end

    // reset: reads pending but suppressed
    tick;
    push(32'h11);
    #1;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("rst_en%0d", c), en[0] | en[1], 1'b0);
      chk($sformatf("rst_vld%0d", c), ovalid[0], 1'b0);
      tick;
    end
    n_avail[0] = 0;
    n_avail[1] = 0;
    rst_n = 1'b1;
    tick;
    chk("rst_lvl", olvl[0], 2'd0);
    chk("rst_vld_rel", ovalid[0], 1'b0);

    // single word
    tick; tick; tick;
    push(32'hA5);
    #1;
    chk("sw_en", en[0], 1'b1);
    chk("sw_addr", raddr[0], faddr[0]);
    tick;
    chk("sw_nobyp", ovalid[0], 1'b0);
    tick;
    chk("sw_vld", ovalid[0], 1'b1);
    chk("sw_data", odata[0], 32'hA5);
    chk("sw_lvl", olvl[0], 2'd1);
    rdy = 1'b1;
    repeat (4) tick;

    // stream of 16 at full rate
    for (int k = 0; k < 16; k++) push(k);
    #1;
    enb = '{0, 0};
    vb  = '{0, 0};
    for (int j = 0; j < 22; j++) begin
      for (int i = 0; i < 2; i++) begin
        if (en[i] !== (j < 16)) enb[i]++;
        if (ovalid[i] !== (j >= i + 2 && j < i + 18)) vb[i]++;
      end
      tick;
    end
    chk("stream_en0", enb[0], 0);
    chk("stream_en1", enb[1], 0);
    chk("stream_vld0", vb[0], 0);
    chk("stream_vld1", vb[1], 0);

    // backpressure
    rdy = 1'b0;
    for (int k = 0; k < 6; k++) push(32'h100 + k);
    #1;
    ec = '{0, 0};
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 2; i++) if (en[i]) ec[i]++;
      tick;
    end
    chk("bp_cnt0", ec[0], 2);
    chk("bp_cnt1", ec[1], 3);
    chk("bp_en0", en[0], 1'b0);
    chk("bp_lvl0", olvl[0], 2'd2);
    chk("bp_lvl1", olvl[1], 2'd3);
    chk("bp_data0", odata[0], 32'h100);
    chk("bp_data1", odata[1], 32'h100);
    rdy = 1'b1;
    for (int j = 0; j < 30; j++) begin
      if (out_ptr[0] == n_avail[0] && out_ptr[1] == n_avail[1]) break;
      tick;
    end
    chk("bp_drain0", out_ptr[0], 23);
    chk("bp_drain1", out_ptr[1], 23);

    // clear with one word in flight and one buffered
    rdy = 1'b0;
    push(32'h200);
    #1;
    tick;
    push(32'h201);
    #1;
    tick;
    chk("clr_pre_lvl", olvl[0], 2'd1);
    clear = 1'b1;
    n_avail[0] = rd_ptr[0];
    n_avail[1] = rd_ptr[1];
    #1;
    chk("clr_en", en[0], 1'b0);
    tick;
    clear = 1'b0;
    #1;
    chk("clr_vld", ovalid[0], 1'b0);
    chk("clr_lvl", olvl[0], 2'd0);
    push(32'h300);
    rdy = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (ovalid[0]) break;
      tick;
    end
    chk("clr_first", odata[0], 32'h300);
    repeat (6) tick;

    // pointer wrap with toggling ready
    for (int k = 0; k < 9; k++) push(32'h400 + k);
    maxl = '{0, 0};
    for (int j = 0; j < 80; j++) begin
      rdy = j[0];
      #1;
      for (int i = 0; i < 2; i++)
        if (int'(olvl[i]) > maxl[i]) maxl[i] = int'(olvl[i]);
      if (out_ptr[0] == n_avail[0] && out_ptr[1] == n_avail[1]) break;
      tick;
    end
    chk("wrap_max0", maxl[0] <= 2, 1'b1);
    chk("wrap_max1", maxl[1] <= 3, 1'b1);
    chk("wrap_done0", out_ptr[0], 35);
    chk("wrap_done1", out_ptr[1], 35);
    chk("ram_port", ramerr[0] + ramerr[1], 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
